// File: rtl/mag_compare_seq.sv
// mag_compare_seq: resolves a wide magnitude compare from a stream of 2-bit slice
// g/e/l results arriving MSB slice first, and hands one registered verdict per
// operand pair to the consumer through a valid/ready handshake.
//
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   in_valid/in_ready      slice handshake (accept = in_valid & in_ready)
//   in_first/in_last       slice opens / closes a compare
//   in_g/in_e/in_l         slice result, expected one-hot
//   out_valid/out_ready    verdict handshake
//   out_g/out_e/out_l      wide verdict, one-hot while out_valid
//   out_slices             slices accepted in the compare, saturating at MAX_SLICES
//   err                    sticky protocol error, cleared only by rst
module mag_compare_seq #(
  parameter int unsigned MAX_SLICES = 16,
  localparam int unsigned CNT_W     = $clog2(MAX_SLICES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_first,
  input  logic             in_last,
  input  logic             in_g,
  input  logic             in_e,
  input  logic             in_l,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_g,
  output logic             out_e,
  output logic             out_l,
  output logic [CNT_W-1:0] out_slices,
  output logic             err
);

  typedef enum logic [1:0] {StIdle, StEq, StDecided, StHold} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             verd_g_q, verd_g_d;
  logic             verd_l_q, verd_l_d;
  logic             out_valid_q, out_valid_d;
  logic             out_g_q, out_g_d;
  logic             out_e_q, out_e_d;
  logic             out_l_q, out_l_d;
  logic [CNT_W-1:0] out_slices_q, out_slices_d;
  logic             err_q, err_d;

  logic accept;
  logic open_cmp;
  logic slice_legal;
  logic slice_g;
  logic slice_l;

  assign in_ready = ~rst & (state_q != StHold);
  assign accept   = in_valid & in_ready;
  assign open_cmp = (state_q == StEq) || (state_q == StDecided);

  // An illegal code contributes nothing to the verdict, i.e. it acts as "equal".
  assign slice_legal = (in_g + in_e + in_l) == 2'd1;
  assign slice_g     = slice_legal & in_g;
  assign slice_l     = slice_legal & in_l;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    verd_g_d     = verd_g_q;
    verd_l_d     = verd_l_q;
    out_valid_d  = out_valid_q;
    out_g_d      = out_g_q;
    out_e_d      = out_e_q;
    out_l_d      = out_l_q;
    out_slices_d = out_slices_q;
    err_d        = err_q;

    if (state_q == StHold) begin
      if (out_ready) begin
        out_valid_d = 1'b0;
        state_d     = StIdle;
      end
    end else if (accept) begin
      if (!slice_legal) err_d = 1'b1;

      if (in_first) begin
        // A first slice while a compare is open aborts it and restarts cleanly.
        if (open_cmp) err_d = 1'b1;
        cnt_d    = CNT_W'(1);
        verd_g_d = slice_g;
        verd_l_d = slice_l;
      end else if (open_cmp) begin
        if (cnt_q == CNT_W'(MAX_SLICES)) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // Once decided, the MSB-most unequal slice owns the verdict.
        if (state_q == StEq) begin
          verd_g_d = slice_g;
          verd_l_d = slice_l;
        end
      end else begin
        // Non-first slice with no compare open is dropped.
        err_d = 1'b1;
      end

      if (in_first || open_cmp) begin
        state_d = (verd_g_d | verd_l_d) ? StDecided : StEq;
        if (in_last) begin
          out_valid_d  = 1'b1;
          out_g_d      = verd_g_d;
          out_l_d      = verd_l_d;
          out_e_d      = ~(verd_g_d | verd_l_d);
          out_slices_d = cnt_d;
          state_d      = StHold;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      verd_g_q     <= 1'b0;
      verd_l_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_g_q      <= 1'b0;
      out_e_q      <= 1'b0;
      out_l_q      <= 1'b0;
      out_slices_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      verd_g_q     <= verd_g_d;
      verd_l_q     <= verd_l_d;
      out_valid_q  <= out_valid_d;
      out_g_q      <= out_g_d;
      out_e_q      <= out_e_d;
      out_l_q      <= out_l_d;
      out_slices_q <= out_slices_d;
      err_q        <= err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_g      = out_g_q;
  assign out_e      = out_e_q;
  assign out_l      = out_l_q;
  assign out_slices = out_slices_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mag_compare_seq.sv
// Directed bench for mag_compare_seq: slices are driven on the falling edge,
// outputs sampled 1 time unit after the rising edge.
module tb_mag_compare_seq;

  localparam int unsigned MaxSlices = 16;
  localparam int unsigned CntW      = $clog2(MaxSlices + 1);

  localparam logic [2:0] CodeG  = 3'b100;
  localparam logic [2:0] CodeE  = 3'b010;
  localparam logic [2:0] CodeL  = 3'b001;
  localparam logic [2:0] CodeGl = 3'b101;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, in_first, in_last, in_g, in_e, in_l;
  logic            out_valid, out_ready, out_g, out_e, out_l, err;
  logic [CntW-1:0] out_slices;

  int n_tests = 0;
  int n_fail  = 0;

  mag_compare_seq #(.MAX_SLICES(MaxSlices)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_first   (in_first),
    .in_last    (in_last),
    .in_g       (in_g),
    .in_e       (in_e),
    .in_l       (in_l),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_g      (out_g),
    .out_e      (out_e),
    .out_l      (out_l),
    .out_slices (out_slices),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One beat, accepted at the rising edge if in_ready; returns #1 after that edge.
  task automatic send(input logic first, input logic last, input logic [2:0] code);
    @(negedge clk);
    in_valid = 1'b1;
    in_first = first;
    in_last  = last;
    {in_g, in_e, in_l} = code;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_in_ready", in_ready, 0);
    step();
    step();
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_verdict", {out_g, out_e, out_l}, 0);
    check_eq("rst_slices", out_slices, 0);
    check_eq("rst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_rel_in_ready", in_ready, 1);
  endtask

  task automatic check_verdict(input string tag, input logic [2:0] gel, input int slices,
                               input logic exp_err);
    check_eq({tag, "_valid"}, out_valid, 1);
    check_eq({tag, "_gel"}, {out_g, out_e, out_l}, gel);
    check_eq({tag, "_slices"}, out_slices, slices);
    check_eq({tag, "_err"}, err, exp_err);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    in_g = 1'b0; in_e = 1'b0; in_l = 1'b0;
    out_ready = 1'b1;
    do_reset();

    // 1: e,e,g,l -> g after 4 slices, one-cycle latency, then drops.
    send(1, 0, CodeE);
    send(0, 0, CodeE);
    send(0, 0, CodeG);
    check_eq("t1_not_yet_valid", out_valid, 0);
    send(0, 1, CodeL);
    check_verdict("t1", CodeG, 4, 0);
    step();
    check_eq("t1_valid_drop", out_valid, 0);
    check_eq("t1_ready_back", in_ready, 1);

    // 2: 16 equal slices, then a single first&last beat with l.
    for (int i = 0; i < 16; i++) send(i == 0, i == 15, CodeE);
    check_verdict("t2a", CodeE, 16, 0);
    step();
    send(1, 1, CodeL);
    check_verdict("t2b", CodeL, 1, 0);
    step();

    // 3: consumer stalls for 5 cycles; offered beats must not be accepted.
    out_ready = 1'b0;
    send(1, 0, CodeE);
    send(0, 1, CodeG);
    check_verdict("t3", CodeG, 2, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1;
      {in_g, in_e, in_l} = CodeL;
      step();
      check_eq("t3_hold_valid", out_valid, 1);
      check_eq("t3_hold_gel", {out_g, out_e, out_l}, CodeG);
      check_eq("t3_hold_slices", out_slices, 2);
      check_eq("t3_hold_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    step();
    check_eq("t3_release_valid", out_valid, 0);
    check_eq("t3_release_in_ready", in_ready, 1);
    check_eq("t3_retain_gel", {out_g, out_e, out_l}, CodeG);

    // 4: stray non-first slice in IDLE, then a legal l,g compare.
    send(0, 1, CodeG);
    check_eq("t4_stray_err", err, 1);
    check_eq("t4_stray_no_valid", out_valid, 0);
    send(1, 0, CodeL);
    send(0, 1, CodeG);
    check_verdict("t4", CodeL, 2, 1);
    step();
    do_reset();

    // 5a: illegal g&l code mid-stream counts as equal.
    send(1, 0, CodeE);
    send(0, 0, CodeGl);
    send(0, 1, CodeG);
    check_verdict("t5a", CodeG, 3, 1);
    step();
    do_reset();

    // 5b: 17 slices, count saturates at 16 and flags err only on overflow.
    for (int i = 0; i < 16; i++) send(i == 0, 1'b0, CodeE);
    check_eq("t5b_no_err_at_16", err, 0);
    send(0, 1, CodeE);
    check_verdict("t5b", CodeE, 16, 1);
    step();

    // 6: reset mid-compare, then a fresh single-slice compare.
    do_reset();
    send(1, 0, CodeE);
    send(0, 0, CodeG);
    do_reset();
    send(1, 1, CodeE);
    check_verdict("t6", CodeE, 1, 0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
